// File: rtl/prec_pkg.sv
// Shared definitions for the precision un-merge stage: precision codes,
// field widths of each container level, FSM states and small helpers.
package prec_pkg;

  localparam logic [1:0] PRE_P8  = 2'b00;
  localparam logic [1:0] PRE_P16 = 2'b01;
  localparam logic [1:0] PRE_P32 = 2'b10;

  // P8 lane: 5b exponent, 17b mantissa
  localparam int LANE8_EXP_W   = 5;
  localparam int LANE8_MANT_W  = 17;
  // Half container (level 01): 10b exponent, 28b mantissa
  localparam int HALF_EXP_W    = 10;
  localparam int HALF_MANT_W   = 28;
  // Full container (level 10): 20b exponent, 56b mantissa
  localparam int CONT_EXP_W    = 20;
  localparam int CONT_MANT_W   = 56;
  // P16 lane: 10b exponent, 34b mantissa
  localparam int LANE16_EXP_W  = 10;
  localparam int LANE16_MANT_W = 34;
  // Lane-packed output bus
  localparam int OUT_EXP_W     = 20;
  localparam int OUT_MANT_W    = 68;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_STEP = 3'd2,
    ST_PACK = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // Only three container/lane pairings have a defined narrowing path.
  function automatic logic pair_legal(input logic [1:0] in_pre, input logic [1:0] out_pre);
    logic ok;
    ok = 1'b0;
    if ((in_pre == PRE_P16) && (out_pre == PRE_P8)) begin
      ok = 1'b1;
    end else if ((in_pre == PRE_P32) && (out_pre == PRE_P16)) begin
      ok = 1'b1;
    end else if ((in_pre == PRE_P32) && (out_pre == PRE_P8)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // A full container heading for P8 lanes needs one split before packing.
  function automatic logic need_step(input logic [1:0] in_pre, input logic [1:0] out_pre);
    return (in_pre == PRE_P32) && (out_pre == PRE_P8);
  endfunction

  // Bits of a half container that a P8 lane cannot carry.
  function automatic logic half_drop(input logic [HALF_EXP_W-1:0] e, input logic [HALF_MANT_W-1:0] m);
    return (|e[9:5]) | (|m[27:17]);
  endfunction

endpackage

// File: rtl/prec_unmerge_if.sv
// Handshake and data bundle between the FMA result side and the lane-packed
// narrow side. master drives the inputs of the block, slave is the block.
interface prec_unmerge_if;
  import prec_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_pre;
  logic [1:0]             out_pre;
  logic [3:0]             s_E;
  logic [3:0]             s_F;
  logic [CONT_EXP_W-1:0]  exp_E;
  logic [CONT_EXP_W-1:0]  exp_F;
  logic [CONT_MANT_W-1:0] mant_E;
  logic [CONT_MANT_W-1:0] mant_F;

  logic                   out_valid;
  logic                   out_ready;
  logic [3:0]             s;
  logic [OUT_EXP_W-1:0]   exp;
  logic [OUT_MANT_W-1:0]  mant;
  logic [1:0]             out_pre_o;
  logic [3:0]             trunc;
  logic                   err;

  modport master (
    output in_valid, in_pre, out_pre, s_E, s_F, exp_E, exp_F, mant_E, mant_F, out_ready,
    input  in_ready, out_valid, s, exp, mant, out_pre_o, trunc, err
  );

  modport slave (
    input  in_valid, in_pre, out_pre, s_E, s_F, exp_E, exp_F, mant_E, mant_F, out_ready,
    output in_ready, out_valid, s, exp, mant, out_pre_o, trunc, err
  );

endinterface

// File: rtl/prec_lane_narrow.sv
// One-level split of a full container (20b/56b) into two half containers
// (10b/28b each), reporting whether any discarded bit was set.
module prec_lane_narrow
  import prec_pkg::*;
(
  input  logic [1:0]             s_odd_i,  // container signs {s[3], s[1]}
  input  logic [CONT_EXP_W-1:0]  exp_i,
  input  logic [CONT_MANT_W-1:0] mant_i,
  output logic [3:0]             s_o,
  output logic [CONT_EXP_W-1:0]  exp_o,
  output logic [CONT_MANT_W-1:0] mant_o,
  output logic                   drop_o
);

  // Split the container: low P8-sized fields become the two half containers.
  always_comb begin
    s_o    = {1'b0, s_odd_i[1], 1'b0, s_odd_i[0]};
    exp_o  = {5'b0_0000, exp_i[9:5], 5'b0_0000, exp_i[4:0]};
    mant_o = {11'b000_0000_0000, mant_i[33:17], 11'b000_0000_0000, mant_i[16:0]};
    drop_o = (|exp_i[19:10]) | (|mant_i[55:34]);
  end

endmodule

// File: rtl/prec_unmerge.sv
// Precision un-merge: takes E/F FMA containers, narrows them one level per
// cycle down to the requested lane precision and presents the lane-packed
// result with per-lane truncation flags.
module prec_unmerge
  import prec_pkg::*;
#(
  parameter int WAIT_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  prec_unmerge_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : {CNT_W{1'b0}};

  state_e                 state_q,     state_d;
  logic [CNT_W-1:0]       wait_cnt_q,  wait_cnt_d;
  logic [1:0]             in_pre_q,    in_pre_d;
  logic [1:0]             out_pre_q,   out_pre_d;
  logic [1:0]             cur_q,       cur_d;
  logic [3:0]             trunc_acc_q, trunc_acc_d;
  logic [3:0]             s_e_q,       s_e_d;
  logic [3:0]             s_f_q,       s_f_d;
  logic [CONT_EXP_W-1:0]  exp_e_q,     exp_e_d;
  logic [CONT_EXP_W-1:0]  exp_f_q,     exp_f_d;
  logic [CONT_MANT_W-1:0] mant_e_q,    mant_e_d;
  logic [CONT_MANT_W-1:0] mant_f_q,    mant_f_d;

  logic                   in_ready_q,  in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [3:0]             s_o_q,       s_o_d;
  logic [OUT_EXP_W-1:0]   exp_o_q,     exp_o_d;
  logic [OUT_MANT_W-1:0]  mant_o_q,    mant_o_d;
  logic [1:0]             pre_o_q,     pre_o_d;
  logic [3:0]             trunc_q,     trunc_d;
  logic                   err_q,       err_d;

  logic [3:0]             nar_e_s,    nar_f_s;
  logic [CONT_EXP_W-1:0]  nar_e_exp,  nar_f_exp;
  logic [CONT_MANT_W-1:0] nar_e_mant, nar_f_mant;
  logic                   nar_e_drop, nar_f_drop;

  prec_lane_narrow u_nar_e (
    .s_odd_i ({s_e_q[3], s_e_q[1]}),
    .exp_i   (exp_e_q),
    .mant_i  (mant_e_q),
    .s_o     (nar_e_s),
    .exp_o   (nar_e_exp),
    .mant_o  (nar_e_mant),
    .drop_o  (nar_e_drop)
  );

  prec_lane_narrow u_nar_f (
    .s_odd_i ({s_f_q[3], s_f_q[1]}),
    .exp_i   (exp_f_q),
    .mant_i  (mant_f_q),
    .s_o     (nar_f_s),
    .exp_o   (nar_f_exp),
    .mant_o  (nar_f_mant),
    .drop_o  (nar_f_drop)
  );

  // Next-state, datapath and registered-output computation for the FSM.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    in_pre_d    = in_pre_q;
    out_pre_d   = out_pre_q;
    cur_d       = cur_q;
    trunc_acc_d = trunc_acc_q;
    s_e_d       = s_e_q;
    s_f_d       = s_f_q;
    exp_e_d     = exp_e_q;
    exp_f_d     = exp_f_q;
    mant_e_d    = mant_e_q;
    mant_f_d    = mant_f_q;
    out_valid_d = out_valid_q;
    s_o_d       = s_o_q;
    exp_o_d     = exp_o_q;
    mant_o_d    = mant_o_q;
    pre_o_d     = pre_o_q;
    trunc_d     = trunc_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_pre_d    = bus.in_pre;
          out_pre_d   = bus.out_pre;
          cur_d       = bus.in_pre;
          trunc_acc_d = 4'b0000;
          s_e_d       = bus.s_E;
          s_f_d       = bus.s_F;
          exp_e_d     = bus.exp_E;
          exp_f_d     = bus.exp_F;
          mant_e_d    = bus.mant_E;
          mant_f_d    = bus.mant_F;
          wait_cnt_d  = WAIT_LOAD;
          if (!pair_legal(bus.in_pre, bus.out_pre)) begin
            state_d = ST_PACK;
          end else if (WAIT_CYC > 0) begin
            state_d = ST_WAIT;
          end else if (need_step(bus.in_pre, bus.out_pre)) begin
            state_d = ST_STEP;
          end else begin
            state_d = ST_PACK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == {CNT_W{1'b0}}) begin
          if (need_step(in_pre_q, out_pre_q)) begin
            state_d = ST_STEP;
          end else begin
            state_d = ST_PACK;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end

      // Only the full -> half split exists, so one step always reaches PACK.
      ST_STEP: begin
        s_e_d       = nar_e_s;
        s_f_d       = nar_f_s;
        exp_e_d     = nar_e_exp;
        exp_f_d     = nar_f_exp;
        mant_e_d    = nar_e_mant;
        mant_f_d    = nar_f_mant;
        trunc_acc_d = trunc_acc_q | {nar_f_drop, nar_f_drop, nar_e_drop, nar_e_drop};
        cur_d       = PRE_P16;
        state_d     = ST_PACK;
      end

      ST_PACK: begin
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
        s_o_d       = 4'b0000;
        exp_o_d     = {OUT_EXP_W{1'b0}};
        mant_o_d    = {OUT_MANT_W{1'b0}};
        pre_o_d     = 2'b00;
        trunc_d     = 4'b0000;
        err_d       = 1'b0;
        if (!pair_legal(in_pre_q, out_pre_q)) begin
          err_d = 1'b1;
        end else begin
          case (cur_q)
            PRE_P16: begin
              // Lanes 0..3 = E.c0, E.c1, F.c0, F.c1
              s_o_d    = {s_f_q[2], s_f_q[0], s_e_q[2], s_e_q[0]};
              exp_o_d  = {exp_f_q[14:10], exp_f_q[4:0], exp_e_q[14:10], exp_e_q[4:0]};
              mant_o_d = {mant_f_q[44:28], mant_f_q[16:0], mant_e_q[44:28], mant_e_q[16:0]};
              pre_o_d  = PRE_P8;
              trunc_d  = trunc_acc_q | {half_drop(exp_f_q[19:10], mant_f_q[55:28]),
                                        half_drop(exp_f_q[9:0],   mant_f_q[27:0]),
                                        half_drop(exp_e_q[19:10], mant_e_q[55:28]),
                                        half_drop(exp_e_q[9:0],   mant_e_q[27:0])};
            end
            PRE_P32: begin
              s_o_d    = {s_f_q[3], 1'b0, s_e_q[3], 1'b0};
              exp_o_d  = {exp_f_q[9:0], exp_e_q[9:0]};
              mant_o_d = {mant_f_q[33:0], mant_e_q[33:0]};
              pre_o_d  = PRE_P16;
              trunc_d  = {nar_f_drop, 1'b0, nar_e_drop, 1'b0};
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          s_o_d       = 4'b0000;
          exp_o_d     = {OUT_EXP_W{1'b0}};
          mant_o_d    = {OUT_MANT_W{1'b0}};
          pre_o_d     = 2'b00;
          trunc_d     = 4'b0000;
          err_d       = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= {CNT_W{1'b0}};
      in_pre_q    <= 2'b00;
      out_pre_q   <= 2'b00;
      cur_q       <= 2'b00;
      trunc_acc_q <= 4'b0000;
      s_e_q       <= 4'b0000;
      s_f_q       <= 4'b0000;
      exp_e_q     <= {CONT_EXP_W{1'b0}};
      exp_f_q     <= {CONT_EXP_W{1'b0}};
      mant_e_q    <= {CONT_MANT_W{1'b0}};
      mant_f_q    <= {CONT_MANT_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s_o_q       <= 4'b0000;
      exp_o_q     <= {OUT_EXP_W{1'b0}};
      mant_o_q    <= {OUT_MANT_W{1'b0}};
      pre_o_q     <= 2'b00;
      trunc_q     <= 4'b0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      in_pre_q    <= in_pre_d;
      out_pre_q   <= out_pre_d;
      cur_q       <= cur_d;
      trunc_acc_q <= trunc_acc_d;
      s_e_q       <= s_e_d;
      s_f_q       <= s_f_d;
      exp_e_q     <= exp_e_d;
      exp_f_q     <= exp_f_d;
      mant_e_q    <= mant_e_d;
      mant_f_q    <= mant_f_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      s_o_q       <= s_o_d;
      exp_o_q     <= exp_o_d;
      mant_o_q    <= mant_o_d;
      pre_o_q     <= pre_o_d;
      trunc_q     <= trunc_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_o_q;
  assign bus.exp       = exp_o_q;
  assign bus.mant      = mant_o_q;
  assign bus.out_pre_o = pre_o_q;
  assign bus.trunc     = trunc_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_prec_unmerge.sv
// Bench for prec_unmerge: randomized and directed bundles, scoreboard queue
// of model-predicted results, and a monitor that checks every presented
// result (data, latency, stability under back-pressure).
module tb_prec_unmerge;

  typedef struct {
    logic [3:0]   s;
    logic [19:0]  exp;
    logic [67:0]  mant;
    logic [1:0]   pre;
    logic [3:0]   trunc;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   ready_mode;  // 0 random, 1 forced low, 2 forced high
  exp_t sb[$];

  prec_unmerge_if bus();
  prec_unmerge_if bus0();

  prec_unmerge #(.WAIT_CYC(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  prec_unmerge #(.WAIT_CYC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Lane-level reference: each output lane is read straight out of the
  // original container with shifts and masks.
  function automatic exp_t model(input logic [1:0] ip, input logic [1:0] op,
                                 input logic [3:0] se, input logic [3:0] sf,
                                 input logic [19:0] ee, input logic [19:0] ef,
                                 input logic [55:0] me, input logic [55:0] mf, input int w);
    exp_t r;
    logic [3:0] sg [2];
    longint unsigned ex [2];
    longint unsigned mn [2];
    longint unsigned he, hm;
    int k;
    r.s = '0; r.exp = '0; r.mant = '0; r.pre = '0; r.trunc = '0; r.err = 1'b0; r.cyc = 2;
    sg[0] = se; sg[1] = sf;
    ex[0] = 64'(ee); ex[1] = 64'(ef);
    mn[0] = 64'(me); mn[1] = 64'(mf);
    if (ip == 2'b01 && op == 2'b00) begin
      for (int x = 0; x < 2; x++) begin
        for (int h = 0; h < 2; h++) begin
          k  = 2 * x + h;
          he = (ex[x] >> (10 * h)) & 64'h3FF;
          hm = (mn[x] >> (28 * h)) & 64'hFFF_FFFF;
          r.exp[5*k +: 5]   = 5'(he & 64'h1F);
          r.mant[17*k +: 17] = 17'(hm & 64'h1_FFFF);
          r.trunc[k] = ((he >> 5) != 0) || ((hm >> 17) != 0);
          r.s[k] = sg[x][2*h];
        end
      end
      r.cyc = w + 2;
    end else if (ip == 2'b10 && op == 2'b00) begin
      for (int x = 0; x < 2; x++) begin
        for (int h = 0; h < 2; h++) begin
          k = 2 * x + h;
          r.exp[5*k +: 5]    = 5'((ex[x] >> (5 * h)) & 64'h1F);
          r.mant[17*k +: 17] = 17'((mn[x] >> (17 * h)) & 64'h1_FFFF);
          r.trunc[k] = ((ex[x] >> 10) != 0) || ((mn[x] >> 34) != 0);
          r.s[k] = sg[x][2*h+1];
        end
      end
      r.cyc = w + 3;
    end else if (ip == 2'b10 && op == 2'b01) begin
      for (int x = 0; x < 2; x++) begin
        r.exp[10*x +: 10]  = 10'(ex[x] & 64'h3FF);
        r.mant[34*x +: 34] = 34'(mn[x] & 64'h3_FFFF_FFFF);
        r.s[2*x+1]     = sg[x][3];
        r.trunc[2*x+1] = ((ex[x] >> 10) != 0) || ((mn[x] >> 34) != 0);
      end
      r.pre = 2'b01;
      r.cyc = w + 2;
    end else begin
      r.err = 1'b1;
      r.cyc = 2;
    end
    return r;
  endfunction

  task automatic scramble_inputs();
    bus.in_pre  = 2'($urandom);
    bus.out_pre = 2'($urandom);
    bus.s_E     = 4'($urandom);
    bus.s_F     = 4'($urandom);
    bus.exp_E   = 20'($urandom);
    bus.exp_F   = 20'($urandom);
    bus.mant_E  = {24'($urandom), 32'($urandom)};
    bus.mant_F  = {24'($urandom), 32'($urandom)};
  endtask

  // Present one bundle to the WAIT_CYC=4 instance; push the prediction at accept.
  task automatic send(input logic [1:0] ip, input logic [1:0] op,
                      input logic [3:0] se, input logic [3:0] sf,
                      input logic [19:0] ee, input logic [19:0] ef,
                      input logic [55:0] me, input logic [55:0] mf, input bit push);
    exp_t e;
    bit ok;
    bus.in_pre = ip; bus.out_pre = op;
    bus.s_E = se; bus.s_F = sf; bus.exp_E = ee; bus.exp_F = ef;
    bus.mant_E = me; bus.mant_F = mf;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_wait", ok, 1'b1);
    if (ok && push) begin
      e = model(ip, op, se, sf, ee, ef, me, mf, 4);
      e.cyc = cyc + e.cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Directed run on the WAIT_CYC=0 instance with inline latency/data checks.
  task automatic run0(input logic [1:0] ip, input logic [1:0] op,
                      input logic [3:0] se, input logic [3:0] sf,
                      input logic [19:0] ee, input logic [19:0] ef,
                      input logic [55:0] me, input logic [55:0] mf);
    exp_t e;
    int got;
    bit ok;
    e = model(ip, op, se, sf, ee, ef, me, mf, 0);
    bus0.in_pre = ip; bus0.out_pre = op;
    bus0.s_E = se; bus0.s_F = sf; bus0.exp_E = ee; bus0.exp_F = ef;
    bus0.mant_E = me; bus0.mant_F = mf;
    bus0.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("w0_accept_wait", ok, 1'b1);
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    bus0.mant_E = '1;
    bus0.in_pre = ~ip;
    got = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (bus0.out_valid) begin
        got = j;
        break;
      end
    end
    chk("w0_latency", got, e.cyc);
    chk("w0_s", bus0.s, e.s);
    chk("w0_exp", bus0.exp, e.exp);
    chk("w0_mant", bus0.mant, e.mant);
    chk("w0_pre", bus0.out_pre_o, e.pre);
    chk("w0_trunc", bus0.trunc, e.trunc);
    chk("w0_err", bus0.err, e.err);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver for the main instance.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1)      bus.out_ready = 1'b0;
      else if (ready_mode == 2) bus.out_ready = 1'b1;
      else                      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare every presented result with the scoreboard head.
  initial begin
    bit held;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", bus.out_valid, 1'b0);
        end else begin
          e = sb[0];
          if (!held) chk("latency", cyc, e.cyc);
          chk("s", bus.s, e.s);
          chk("exp", bus.exp, e.exp);
          chk("mant", bus.mant, e.mant);
          chk("pre_o", bus.out_pre_o, e.pre);
          chk("trunc", bus.trunc, e.trunc);
          chk("err", bus.err, e.err);
          held = 1'b1;
          if (bus.out_ready) begin
            void'(sb.pop_front());
            held = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [1:0] pick_pair_in(input int sel);
    if (sel < 3)      return 2'b01;
    else if (sel < 8) return 2'b10;
    else              return 2'($urandom);
  endfunction

  initial begin
    logic [1:0]  ip, op;
    logic [19:0] ee, ef, emask;
    logic [55:0] me, mf, mmask;
    int sel;
    bit ok;

    n_checks = 0;
    n_fail = 0;
    ready_mode = 2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b1;
    scramble_inputs();
    bus0.in_pre = 2'b00; bus0.out_pre = 2'b00;
    bus0.s_E = '0; bus0.s_F = '0; bus0.exp_E = '0; bus0.exp_F = '0;
    bus0.mant_E = '0; bus0.mant_F = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_mant", bus.mant, 68'd0);
    chk("rst_exp", bus.exp, 20'd0);
    chk("rst_trunc_err", {bus.trunc, bus.err, bus.s, bus.out_pre_o}, 11'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed cases on the WAIT_CYC=4 instance
    send(2'b01, 2'b00, 4'b0101, 4'b0000, {10'd3, 10'd1}, 20'd0, {28'd7, 28'd5}, 56'd0, 1'b1);
    send(2'b10, 2'b01, 4'b1000, 4'b1010, 20'd0, 20'h00400, 56'd0, 56'd1 << 40, 1'b1);
    send(2'b10, 2'b00, 4'b1111, 4'b0010, 20'h0_03E5, 20'h0_0400, 56'h3_0002_0001, 56'd1 << 34, 1'b1);
    send(2'b00, 2'b01, 4'hF, 4'hF, 20'hFFFFF, 20'hFFFFF, '1, '1, 1'b1);
    send(2'b11, 2'b00, 4'hF, 4'hF, 20'hFFFFF, 20'hFFFFF, '1, '1, 1'b1);
    send(2'b01, 2'b01, 4'hA, 4'h5, 20'h12345, 20'h54321, '1, '1, 1'b1);

    // Back-pressure: result held for 5 cycles while in_valid pulses are refused
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_before_hold", ok, 1'b1);
    ready_mode = 1;
    send(2'b01, 2'b00, 4'b1001, 4'b0110, 20'hABCDE, 20'h13579, 56'h12_3456_789A_BCDE, 56'hFE_DCBA_9876_5432, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hold_valid_seen", ok, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      scramble_inputs();
      @(negedge clk);
      chk("hold_in_ready", bus.in_ready, 1'b0);
      chk("hold_out_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    ready_mode = 2;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hold_release", ok, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1'b1);
    chk("release_out_valid", bus.out_valid, 1'b0);
    chk("release_cleared", {bus.exp, bus.mant}, 88'd0);
    @(posedge clk);
    #1;

    // Reset during WAIT aborts the operation
    send(2'b01, 2'b00, 4'hF, 4'hF, 20'hFFFFF, 20'hFFFFF, '1, '1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_low", bus.in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_idle", bus.in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure
    ready_mode = 0;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      ip = pick_pair_in(sel);
      if (sel < 3)      op = 2'b00;
      else if (sel < 6) op = 2'b00;
      else if (sel < 8) op = 2'b01;
      else              op = 2'($urandom);
      ee = 20'($urandom); ef = 20'($urandom);
      me = {24'($urandom), 32'($urandom)};
      mf = {24'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 0) begin
        if (ip == 2'b01) begin
          emask = 20'h0_7C1F;
          mmask = 56'h00_1FFF_F001_FFFF;
        end else if (op == 2'b00) begin
          emask = 20'h0_03FF;
          mmask = 56'h00_0003_FFFF_FFFF;
        end else begin
          emask = 20'h0_03FF;
          mmask = 56'h00_0003_FFFF_FFFF;
        end
        ee = ee & emask; ef = ef & emask;
        me = me & mmask; mf = mf & mmask;
      end
      send(ip, op, 4'($urandom), 4'($urandom), ee, ef, me, mf, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // WAIT_CYC=0 instance: shortest latencies
    run0(2'b10, 2'b00, 4'b1010, 4'b0000, 20'h0_0000, 20'd0, 56'h3_0002_0001, 56'd0);
    run0(2'b01, 2'b00, 4'b0101, 4'b0011, {10'd3, 10'd1}, {10'd30, 10'd2}, {28'd7, 28'd5}, {28'h40000, 28'd9});
    run0(2'b10, 2'b01, 4'b1000, 4'b1000, 20'h0_0155, 20'h0_0400, 56'h0_0001_2345_6789, 56'd1 << 40);
    run0(2'b11, 2'b00, 4'hF, 4'hF, 20'hFFFFF, 20'hFFFFF, '1, '1);

    ready_mode = 2;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("final_drain", ok, 1'b1);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
